// File: rtl/ps2_key_controller.sv
// rtl/ps2_key_controller.sv - PS/2 keyboard frame capture, E0/F0 folding and key event handshake
// Optional macro PS2_PARITY_CHECK_EN: reject frames with bad odd parity.
module ps2_key_controller #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int TIMEOUT_W      = 16
) (
  input  logic       CLK,
  input  logic       Resetn,
  input  logic       PS2Clk,
  input  logic       PS2Data,
  output logic [7:0] KeyCode,
  output logic       KeyRelease,
  output logic       KeyExtended,
  output logic       KeyValid,
  input  logic       KeyAck,
  output logic       FrameErr,
  output logic       Overrun
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic                   clk_prev;
  logic                   sync_clk, sync_data, fall;
  state_t                 state, state_n;
  logic [2:0]             bitcnt;
  logic [7:0]             shreg;
  logic                   parity_bit, parity_ok;
  logic [TIMEOUT_W-1:0]   tcnt;
  logic                   ext_flag, rel_flag;
  logic                   byte_done, frame_err_n, timeout, is_event;

  assign sync_clk  = clk_sync[SYNC_STAGES-1];
  assign sync_data = data_sync[SYNC_STAGES-1];
  assign fall      = clk_prev & ~sync_clk;
  assign is_event  = byte_done && (shreg != 8'hE0) && (shreg != 8'hF0);

`ifdef PS2_PARITY_CHECK_EN
  assign parity_ok = ^{shreg, parity_bit};
`else
  assign parity_ok = parity_bit | 1'b1;
`endif

  // Synchronisers idle high, matching an undriven PS/2 bus.
  always_ff @(posedge CLK or negedge Resetn) begin
    if (!Resetn) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], PS2Clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], PS2Data};
      clk_prev  <= sync_clk;
    end
  end

  always_ff @(posedge CLK or negedge Resetn) begin
    if (!Resetn) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n     = state;
    byte_done   = 1'b0;
    frame_err_n = 1'b0;
    timeout     = 1'b0;
    if (state != IDLE && !fall && tcnt == TO_LAST) begin
      timeout     = 1'b1;
      frame_err_n = 1'b1;
      state_n     = IDLE;
    end else if (fall) begin
      case (state)
        IDLE:    if (!sync_data) state_n = DATA;
        DATA:    if (bitcnt == 3'd7) state_n = PARITY;
        PARITY:  state_n = STOP;
        STOP: begin
          state_n = IDLE;
          if (sync_data && parity_ok) byte_done   = 1'b1;
          else                        frame_err_n = 1'b1;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge Resetn) begin
    if (!Resetn) begin
      bitcnt     <= 3'd0;
      shreg      <= 8'h00;
      parity_bit <= 1'b0;
      tcnt       <= '0;
    end else begin
      if (state == IDLE || fall || timeout) tcnt <= '0;
      else                                  tcnt <= tcnt + 1'b1;
      if (fall) begin
        case (state)
          IDLE:    bitcnt <= 3'd0;
          DATA: begin
            shreg  <= {sync_data, shreg[7:1]};
            bitcnt <= bitcnt + 3'd1;
          end
          PARITY:  parity_bit <= sync_data;
          default: ;
        endcase
      end
    end
  end

  // Any aborted frame discards pending prefixes so a stale E0/F0 cannot taint the next key.
  always_ff @(posedge CLK or negedge Resetn) begin
    if (!Resetn) begin
      ext_flag    <= 1'b0;
      rel_flag    <= 1'b0;
      FrameErr    <= 1'b0;
      KeyCode     <= 8'h00;
      KeyRelease  <= 1'b0;
      KeyExtended <= 1'b0;
      KeyValid    <= 1'b0;
      Overrun     <= 1'b0;
    end else begin
      FrameErr <= frame_err_n;
      if (frame_err_n) begin
        ext_flag <= 1'b0;
        rel_flag <= 1'b0;
      end else if (byte_done) begin
        if (shreg == 8'hE0)      ext_flag <= 1'b1;
        else if (shreg == 8'hF0) rel_flag <= 1'b1;
        else begin
          ext_flag <= 1'b0;
          rel_flag <= 1'b0;
        end
      end
      if (is_event && (!KeyValid || KeyAck)) begin
        KeyCode     <= shreg;
        KeyRelease  <= rel_flag;
        KeyExtended <= ext_flag;
        KeyValid    <= 1'b1;
      end else if (is_event) begin
        Overrun <= 1'b1;
      end else if (KeyValid && KeyAck) begin
        KeyValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_controller.sv
// tb/tb_ps2_key_controller.sv - self-checking bench for ps2_key_controller
module tb_ps2_key_controller;

  localparam int TO   = 300;
  localparam int HALF = 8;

  logic       CLK = 1'b0;
  logic       Resetn, PS2Clk, PS2Data, KeyAck;
  logic [7:0] KeyCode;
  logic       KeyRelease, KeyExtended, KeyValid, FrameErr, Overrun;

  int errors = 0;
  int checks = 0;
  int ferr_pulses = 0;
  int ferr_cycles = 0;
  logic ferr_prev = 1'b0;

  logic [7:0] exp_code;
  logic       exp_valid, exp_rel, exp_ext, exp_ovr, pfx_e, pfx_f;

  ps2_key_controller #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(TO), .TIMEOUT_W(16)) dut (
    .CLK(CLK), .Resetn(Resetn), .PS2Clk(PS2Clk), .PS2Data(PS2Data),
    .KeyCode(KeyCode), .KeyRelease(KeyRelease), .KeyExtended(KeyExtended),
    .KeyValid(KeyValid), .KeyAck(KeyAck), .FrameErr(FrameErr), .Overrun(Overrun)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (FrameErr) begin
      ferr_cycles++;
      if (!ferr_prev) ferr_pulses++;
    end
    ferr_prev = FrameErr;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [10:0] frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic par;
    par = ~(^b) ^ bad_par;
    return {~bad_stop, par, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      PS2Data = bits[i];
      repeat (HALF) @(negedge CLK);
      PS2Clk = 1'b0;
      repeat (HALF) @(negedge CLK);
      PS2Clk = 1'b1;
    end
    PS2Data = 1'b1;
    repeat (4) @(negedge CLK);
  endtask

  task automatic model_reset();
    exp_valid = 0; exp_code = 8'h00; exp_rel = 0; exp_ext = 0;
    exp_ovr = 0; pfx_e = 0; pfx_f = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b == 8'hE0) pfx_e = 1;
    else if (b == 8'hF0) pfx_f = 1;
    else begin
      if (exp_valid) exp_ovr = 1;
      else begin
        exp_valid = 1; exp_code = b; exp_rel = pfx_f; exp_ext = pfx_e;
      end
      pfx_e = 0; pfx_f = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(frame(b, 0, 0), 11);
    model_byte(b);
  endtask

  task automatic do_ack();
    KeyAck = 1'b1;
    @(negedge CLK);
    KeyAck = 1'b0;
    @(negedge CLK);
    exp_valid = 0;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".valid"}, 32'(KeyValid), 32'(exp_valid));
    if (exp_valid) begin
      check({tag, ".code"}, 32'(KeyCode), 32'(exp_code));
      check({tag, ".rel"},  32'(KeyRelease), 32'(exp_rel));
      check({tag, ".ext"},  32'(KeyExtended), 32'(exp_ext));
    end
    check({tag, ".ovr"}, 32'(Overrun), 32'(exp_ovr));
  endtask

  initial begin
    int p0;
    logic [7:0] b;
    PS2Clk = 1'b1; PS2Data = 1'b1; KeyAck = 1'b0; Resetn = 1'b0;
    model_reset();
    repeat (4) @(negedge CLK);
    check("reset.outs", {20'd0, KeyCode, KeyRelease, KeyExtended, KeyValid, FrameErr, Overrun}, 32'd0);
    Resetn = 1'b1;
    repeat (4) @(negedge CLK);

    send_byte(8'h1C);
    check_model("t1");
    check("t1.code_const", 32'(KeyCode), 32'h1C);
    do_ack();
    check("t1.ack", 32'(KeyValid), 32'd0);

    send_byte(8'hF0);
    check("t2.prefix_only", 32'(KeyValid), 32'd0);
    send_byte(8'h1C);
    check_model("t2");
    check("t2.rel_const", 32'(KeyRelease), 32'd1);
    do_ack();

    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    check_model("t3");
    check("t3.flags_const", {30'd0, KeyExtended, KeyRelease}, 32'd3);
    do_ack();
    send_byte(8'h1C);
    check_model("t3b");
    do_ack();

    p0 = ferr_pulses;
    send_bits(frame(8'h1C, 1, 0), 11);
`ifdef PS2_PARITY_CHECK_EN
    check("t4.ferr", 32'(ferr_pulses), 32'(p0 + 1));
    pfx_e = 0; pfx_f = 0;
`else
    check("t4.ferr", 32'(ferr_pulses), 32'(p0));
    model_byte(8'h1C);
`endif
    check_model("t4");
    if (exp_valid) do_ack();

    p0 = ferr_pulses;
    send_bits(frame(8'h1C, 0, 1), 11);
    check("stop.ferr", 32'(ferr_pulses), 32'(p0 + 1));
    check("stop.noevent", 32'(KeyValid), 32'd0);
    pfx_e = 0; pfx_f = 0;

    send_byte(8'hF0);
    p0 = ferr_pulses;
    send_bits(frame(8'h29, 0, 0), 5);
    repeat (TO / 2) @(negedge CLK);
    check("t5.early", 32'(ferr_pulses), 32'(p0));
    repeat (TO) @(negedge CLK);
    check("t5.timeout", 32'(ferr_pulses), 32'(p0 + 1));
    pfx_e = 0; pfx_f = 0;
    send_byte(8'h29);
    check_model("t5");
    check("t5.rel_cleared", 32'(KeyRelease), 32'd0);
    do_ack();

    send_byte(8'h1C); send_byte(8'h32);
    check_model("t6");
    check("t6.kept", {23'd0, KeyCode, Overrun}, {23'd0, 8'h1C, 1'b1});

    p0 = ferr_pulses;
    send_bits(frame(8'h44, 0, 0), 4);
    Resetn = 1'b0;
    repeat (3) @(negedge CLK);
    check("t6.reset_outs", {20'd0, KeyCode, KeyRelease, KeyExtended, KeyValid, FrameErr, Overrun}, 32'd0);
    Resetn = 1'b1;
    model_reset();
    repeat (4) @(negedge CLK);
    check("t6.no_ferr", 32'(ferr_pulses), 32'(p0));
    send_byte(8'h1C);
    check_model("t6b");
    do_ack();

    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 9))
        0: b = 8'hE0;
        1: b = 8'hF0;
        default: begin
          b = 8'($urandom_range(0, 255));
          while (b == 8'hE0 || b == 8'hF0) b = 8'($urandom_range(0, 255));
        end
      endcase
      send_byte(b);
      check_model($sformatf("rnd%0d", i));
      if ($urandom_range(0, 2) != 0) begin
        do_ack();
        check($sformatf("rnd%0d.ack", i), 32'(KeyValid), 32'd0);
      end
    end

    check("ferr.width", 32'(ferr_cycles), 32'(ferr_pulses));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
